// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - MEM-stage word access sequenced as two 16-bit SRAM half accesses
// Optional SRAM_STATS_EN adds saturating read/write/stall counters.
module sram_mem_ctrl #(
    parameter int          ADDR_W    = 17,
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int          SRAM_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       ALU_Res,
    input  logic [31:0]       ST_Val,
    output logic [31:0]       MEM_Result,
    output logic              ready,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [15:0]       SRAM_WDATA,
    output logic              SRAM_WE_N,
    input  logic [15:0]       SRAM_RDATA
`ifdef SRAM_STATS_EN
    ,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [2:0] WAIT_LAST = 3'(SRAM_WAIT);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        wait_cnt;
    logic              last_beat;
    logic              req;
    logic              op_wr;
    logic [ADDR_W-2:0] idx;
    logic [15:0]       hi_data;
    logic [31:0]       offset;
    logic [ADDR_W-2:0] idx_in;
    logic              unused_bits;

    assign req         = MEM_R_EN | MEM_W_EN;
    assign last_beat   = (wait_cnt == WAIT_LAST);
    assign offset      = ALU_Res - BASE_ADDR;
    assign idx_in      = offset[ADDR_W:2];
    assign unused_bits = ^{offset[31:ADDR_W+1], offset[1:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) state_nxt = LO;
            end
            LO:   if (last_beat) state_nxt = HI;
            HI:   if (last_beat) state_nxt = DONE;
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address/data/WE_N are registered once per half so the SRAM sees them stable for the whole half.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt   <= 3'd0;
            op_wr      <= 1'b0;
            idx        <= '0;
            hi_data    <= 16'h0;
            SRAM_ADDR  <= '0;
            SRAM_WDATA <= 16'h0;
            SRAM_WE_N  <= 1'b1;
            MEM_Result <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr      <= MEM_W_EN;
                        idx        <= idx_in;
                        hi_data    <= ST_Val[31:16];
                        SRAM_ADDR  <= {idx_in, 1'b0};
                        SRAM_WDATA <= ST_Val[15:0];
                        SRAM_WE_N  <= ~MEM_W_EN;
                        wait_cnt   <= 3'd0;
                    end
                end
                LO: begin
                    if (last_beat) begin
                        if (!op_wr) MEM_Result[15:0] <= SRAM_RDATA;
                        SRAM_ADDR  <= {idx, 1'b1};
                        SRAM_WDATA <= hi_data;
                        wait_cnt   <= 3'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                HI: begin
                    if (last_beat) begin
                        if (!op_wr) MEM_Result[31:16] <= SRAM_RDATA;
                        SRAM_WE_N <= 1'b1;
                        wait_cnt  <= 3'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SRAM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt    <= 16'h0;
            wr_cnt    <= 16'h0;
            stall_cnt <= 16'h0;
        end else begin
            if (state == HI && last_beat) begin
                if (op_wr && wr_cnt != 16'hFFFF)       wr_cnt <= wr_cnt + 16'd1;
                else if (!op_wr && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
            end
            if (!ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb/tb_sram_mem_ctrl.sv - randomized bench for sram_mem_ctrl against a word-level memory model
module tb_sram_mem_ctrl;

    localparam int ADDR_W = 17;
    localparam int BASE   = 1024;
    localparam int WAIT   = 1;
    localparam int STALL  = 2 * (1 + WAIT) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              r_en;
    logic              w_en;
    logic [31:0]       alu_res;
    logic [31:0]       st_val;
    logic [31:0]       mem_result;
    logic              ready;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_wdata;
    logic [15:0]       sram_rdata;
    logic              sram_we_n;
`ifdef SRAM_STATS_EN
    logic [15:0]       rd_cnt;
    logic [15:0]       wr_cnt;
    logic [15:0]       stall_cnt;
`endif

    logic [15:0] sram [0:(1<<ADDR_W)-1];
    logic [31:0] ref_mem [int];
    logic [31:0] exp_result;
    int          exp_rd, exp_wr, exp_stall;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    assign sram_rdata = sram[sram_addr];
    always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_wdata;

    sram_mem_ctrl #(
        .ADDR_W(ADDR_W), .BASE_ADDR(32'(BASE)), .SRAM_WAIT(WAIT)
    ) dut (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en), .MEM_W_EN(w_en),
        .ALU_Res(alu_res), .ST_Val(st_val), .MEM_Result(mem_result),
        .ready(ready), .SRAM_ADDR(sram_addr), .SRAM_WDATA(sram_wdata),
        .SRAM_WE_N(sram_we_n), .SRAM_RDATA(sram_rdata)
`ifdef SRAM_STATS_EN
        , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .stall_cnt(stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int widx_of(input logic [31:0] a);
        logic [31:0] d;
        d = a - 32'(BASE);
        return int'(d[31:2]) & ((1 << (ADDR_W - 1)) - 1);
    endfunction

    // Caller is at negedge+1 in IDLE (from_done=0) or in the DONE cycle (from_done=1).
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input bit from_done);
        int low, welow, guard, w;
        logic [ADDR_W-1:0] ea;
        r_en = rd; w_en = wr; alu_res = addr; st_val = data;
        if (from_done) @(negedge clk);
        #1;
        w = widx_of(addr);
        low = 0; welow = 0; guard = 0;
        while (!ready && guard < 50) begin
            if (low > 0) begin
                ea = {w[ADDR_W-2:0], (low > 1 + WAIT)};
                check("half_addr", 32'(sram_addr), 32'(ea));
            end
            if (!sram_we_n) welow++;
            low++;
            @(negedge clk); #1;
            guard++;
        end
        if (wr) begin
            ref_mem[w] = data;
            exp_wr++;
        end else begin
            exp_result = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
            exp_rd++;
        end
        exp_stall += STALL;
        check("stall_len", 32'(low), 32'(STALL));
        check("we_low_cycles", 32'(welow), wr ? 32'(2 * (1 + WAIT)) : 32'h0);
        check("we_n_done", 32'(sram_we_n), 32'h1);
        check("mem_result", mem_result, exp_result);
        if (wr) begin
            check("sram_lo", 32'(sram[2*w]), 32'(data[15:0]));
            check("sram_hi", 32'(sram[2*w+1]), 32'(data[31:16]));
        end
    endtask

    task automatic idle();
        r_en = 1'b0; w_en = 1'b0;
        @(negedge clk); #1;
        check("ready_idle", 32'(ready), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int start;
        bit at_done;
        for (int i = 0; i < (1 << ADDR_W); i++) sram[i] <= 16'h0;
        rst = 1'b1; r_en = 1'b0; w_en = 1'b0; alu_res = 32'h0; st_val = 32'h0;
        exp_result = 32'h0; exp_rd = 0; exp_wr = 0; exp_stall = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'h1);
        check("rst_result", mem_result, 32'h0);
        check("rst_we_n", 32'(sram_we_n), 32'h1);
        check("rst_addr", 32'(sram_addr), 32'h0);
        check("rst_wdata", 32'(sram_wdata), 32'h0);
        rst = 1'b0;
        @(negedge clk); #1;

        access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0);
        check("dir_sram2", 32'(sram[2]), 32'h0000BEEF);
        check("dir_sram3", 32'(sram[3]), 32'h0000DEAD);
        idle();
        access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        check("readback", mem_result, 32'hDEADBEEF);
        idle();

        start = cycle;
        access(1'b0, 1'b1, 32'd1024, 32'h12345678, 1'b0);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1);
        check("b2b_cycles", 32'(cycle - start + 1), 32'd12);
        check("b2b_load", mem_result, 32'h12345678);
        idle();

        access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 1'b0);
        check("both_result", mem_result, 32'h12345678);
        idle();

        r_en = 1'b1; alu_res = 32'd1028;
        repeat (2 * (1 + WAIT)) @(negedge clk);
        rst = 1'b1; r_en = 1'b0;
        @(negedge clk); #1;
        check("mid_rst_we_n", 32'(sram_we_n), 32'h1);
        check("mid_rst_result", mem_result, 32'h0);
        check("mid_rst_ready", 32'(ready), 32'h1);
        rst = 1'b0;
        exp_result = 32'h0; exp_rd = 0; exp_wr = 0; exp_stall = 0;
        @(negedge clk); #1;

        at_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 2);
            access(op != 1, op != 0, 32'(BASE) + 32'($urandom_range(0, 255)), $urandom, at_done);
            at_done = 1'($urandom_range(0, 1));
            if (!at_done) idle();
        end
        if (at_done) idle();

        access(1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 1'b0);
        idle();
        access(1'b1, 1'b0, 32'd1020, 32'h0, 1'b0);
        check("wrap_load", mem_result, 32'hCAFEF00D);
        idle();

`ifdef SRAM_STATS_EN
        check("rd_cnt", 32'(rd_cnt), 32'(exp_rd));
        check("wr_cnt", 32'(wr_cnt), 32'(exp_wr));
        check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
